// File: rtl/pot_cmd_parser.sv
// Parses 4-byte UART frames (HDR, CMD, VAL, CHK) into MCP41010 wiper writes and
// returns a 1-byte reply; holds the last committed wiper value.
module pot_cmd_parser #(
  parameter logic [7:0]  HDR         = 8'h55,
  parameter int unsigned BYTE_TO_CYC = 50000,
  parameter int unsigned SPI_TO_CYC  = 1000,
  parameter logic [7:0]  WIPER_RST   = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       uart_tx_busy,
  output logic       uart_tx_en,
  output logic [7:0] uart_tx_data,
  output logic       pot_tx_en,
  output logic [7:0] pot_data,
  input  logic       pot_tx_done,
  output logic [7:0] wiper,
  output logic       busy,
  output logic       frame_err,
  output logic       spi_timeout,
  output logic       rx_drop
);

  localparam int unsigned MAX_TO = (BYTE_TO_CYC > SPI_TO_CYC) ? BYTE_TO_CYC : SPI_TO_CYC;
  localparam int unsigned CNT_W  = $clog2(MAX_TO + 1);

  localparam logic [7:0] CMD_WR  = 8'h11;
  localparam logic [7:0] CMD_INC = 8'h21;
  localparam logic [7:0] CMD_DEC = 8'h22;
  localparam logic [7:0] CMD_RD  = 8'h30;
  localparam logic [7:0] ACK     = 8'h06;
  localparam logic [7:0] NAK     = 8'h15;

  typedef enum logic [2:0] {
    HUNT, GET_CMD, GET_VAL, GET_CHK, EXEC, SPI_WAIT, REPLY
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cmd_q, cmd_d, val_q, val_d, chk_q, chk_d, reply_q, reply_d;
  logic [7:0]       wiper_q, wiper_d, pot_data_q, pot_data_d, uart_tx_data_q, uart_tx_data_d;
  logic             uart_tx_en_q, uart_tx_en_d, pot_tx_en_q, pot_tx_en_d;
  logic             busy_q, busy_d, frame_err_q, frame_err_d;
  logic             spi_timeout_q, spi_timeout_d, rx_drop_q, rx_drop_d;

  logic             byte_to_c, done_c, spi_to_c, frame_bad_c;
  logic [8:0]       sum_c;
  logic [7:0]       new_c;

  // Shared condition and new-wiper computation
  always_comb begin
    byte_to_c   = (cnt_q == CNT_W'(BYTE_TO_CYC - 1));
    done_c      = pot_tx_done && !pot_tx_en_q;
    spi_to_c    = !done_c && (cnt_q == CNT_W'(SPI_TO_CYC - 1));
    frame_bad_c = (chk_q != (cmd_q ^ val_q)) ||
                  !((cmd_q == CMD_WR) || (cmd_q == CMD_INC) ||
                    (cmd_q == CMD_DEC) || (cmd_q == CMD_RD));
    sum_c       = {1'b0, wiper_q} + {1'b0, val_q};
    case (cmd_q)
      CMD_INC: new_c = sum_c[8] ? 8'hFF : sum_c[7:0];
      CMD_DEC: new_c = (val_q > wiper_q) ? 8'h00 : (wiper_q - val_q);
      default: new_c = val_q;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:     if (rx_valid && (rx_data == HDR)) state_d = GET_CMD;
      GET_CMD:  if (rx_valid) state_d = GET_VAL; else if (byte_to_c) state_d = HUNT;
      GET_VAL:  if (rx_valid) state_d = GET_CHK; else if (byte_to_c) state_d = HUNT;
      GET_CHK:  if (rx_valid) state_d = EXEC;    else if (byte_to_c) state_d = HUNT;
      EXEC:     state_d = (frame_bad_c || (cmd_q == CMD_RD)) ? REPLY : SPI_WAIT;
      SPI_WAIT: if (done_c || spi_to_c) state_d = REPLY;
      REPLY:    if (!uart_tx_busy) state_d = HUNT;
      default:  state_d = HUNT;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d          = cnt_q;
    cmd_d          = cmd_q;
    val_d          = val_q;
    chk_d          = chk_q;
    reply_d        = reply_q;
    wiper_d        = wiper_q;
    pot_data_d     = pot_data_q;
    uart_tx_data_d = uart_tx_data_q;
    uart_tx_en_d   = 1'b0;
    pot_tx_en_d    = 1'b0;
    frame_err_d    = 1'b0;
    spi_timeout_d  = 1'b0;
    rx_drop_d      = rx_valid && ((state_q == EXEC) || (state_q == SPI_WAIT) ||
                                  (state_q == REPLY));
    busy_d         = (state_d != HUNT);
    case (state_q)
      GET_CMD, GET_VAL, GET_CHK: begin
        if (rx_valid) begin
          cnt_d = '0;
          if (state_q == GET_CMD) cmd_d = rx_data;
          if (state_q == GET_VAL) val_d = rx_data;
          if (state_q == GET_CHK) chk_d = rx_data;
        end else if (byte_to_c) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EXEC: begin
        cnt_d = '0;
        if (frame_bad_c) begin
          frame_err_d = 1'b1;
          reply_d     = NAK;
        end else if (cmd_q == CMD_RD) begin
          reply_d = wiper_q;
        end else begin
          pot_data_d  = new_c;
          pot_tx_en_d = 1'b1;
        end
      end
      SPI_WAIT: begin
        if (done_c) begin
          wiper_d = pot_data_q;
          reply_d = ACK;
        end else if (spi_to_c) begin
          spi_timeout_d = 1'b1;
          reply_d       = NAK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REPLY: begin
        if (!uart_tx_busy) begin
          uart_tx_en_d   = 1'b1;
          uart_tx_data_d = reply_q;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= HUNT;
      cnt_q          <= '0;
      cmd_q          <= '0;
      val_q          <= '0;
      chk_q          <= '0;
      reply_q        <= '0;
      wiper_q        <= WIPER_RST;
      pot_data_q     <= WIPER_RST;
      uart_tx_data_q <= '0;
      uart_tx_en_q   <= 1'b0;
      pot_tx_en_q    <= 1'b0;
      busy_q         <= 1'b0;
      frame_err_q    <= 1'b0;
      spi_timeout_q  <= 1'b0;
      rx_drop_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cmd_q          <= cmd_d;
      val_q          <= val_d;
      chk_q          <= chk_d;
      reply_q        <= reply_d;
      wiper_q        <= wiper_d;
      pot_data_q     <= pot_data_d;
      uart_tx_data_q <= uart_tx_data_d;
      uart_tx_en_q   <= uart_tx_en_d;
      pot_tx_en_q    <= pot_tx_en_d;
      busy_q         <= busy_d;
      frame_err_q    <= frame_err_d;
      spi_timeout_q  <= spi_timeout_d;
      rx_drop_q      <= rx_drop_d;
    end
  end

  assign uart_tx_en   = uart_tx_en_q;
  assign uart_tx_data = uart_tx_data_q;
  assign pot_tx_en    = pot_tx_en_q;
  assign pot_data     = pot_data_q;
  assign wiper        = wiper_q;
  assign busy         = busy_q;
  assign frame_err    = frame_err_q;
  assign spi_timeout  = spi_timeout_q;
  assign rx_drop      = rx_drop_q;

endmodule
